// File: rtl/vga_fb_write_arbiter.sv
// Round-robin write arbiter with full-frame clear engine for the frame buffer.
// Optional VGA_FB_VBLANK_ONLY_EN restricts all writes to vertical blanking.
module vga_fb_write_arbiter #(
   parameter int HD         = 1280,
   parameter int VD         = 1024,
   parameter int X_BITS     = 11,
   parameter int Y_BITS     = 11,
   parameter int COLOR_BITS = 2
) (
   input  logic                  clk_i,
   input  logic                  arst_i,
   input  logic                  vblank_i,
   input  logic                  req0_valid_i,
   output logic                  req0_ready_o,
   input  logic [X_BITS-1:0]     req0_x_i,
   input  logic [Y_BITS-1:0]     req0_y_i,
   input  logic [COLOR_BITS-1:0] req0_color_i,
   input  logic                  req1_valid_i,
   output logic                  req1_ready_o,
   input  logic [X_BITS-1:0]     req1_x_i,
   input  logic [Y_BITS-1:0]     req1_y_i,
   input  logic [COLOR_BITS-1:0] req1_color_i,
   input  logic                  clear_start_i,
   input  logic [COLOR_BITS-1:0] clear_color_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic                  we_o,
   output logic [X_BITS-1:0]     addr_x_o,
   output logic [Y_BITS-1:0]     addr_y_o,
   output logic [COLOR_BITS-1:0] color_o
);

   typedef enum logic {ARB, CLEAR} state_t;

   localparam logic [X_BITS-1:0] XMAX = X_BITS'(HD - 1);
   localparam logic [Y_BITS-1:0] YMAX = Y_BITS'(VD - 1);

   state_t                r_state;
   state_t                w_state_n;
   logic                  r_last1;
   logic                  r_we;
   logic                  r_err;
   logic                  r_done;
   logic                  r_busy;
   logic [X_BITS-1:0]     r_x;
   logic [Y_BITS-1:0]     r_y;
   logic [COLOR_BITS-1:0] r_color;
   logic [COLOR_BITS-1:0] r_clr;
   logic [X_BITS-1:0]     r_cx;
   logic [Y_BITS-1:0]     r_cy;

   logic                  w_vb_ok;
   logic                  w_arb;
   logic                  w_g0;
   logic                  w_g1;
   logic                  w_xfer;
   logic                  w_inr;
   logic                  w_last;
   logic                  w_clr_st;
   logic [X_BITS-1:0]     w_px;
   logic [Y_BITS-1:0]     w_py;
   logic [COLOR_BITS-1:0] w_pc;

`ifdef VGA_FB_VBLANK_ONLY_EN
   assign w_vb_ok = vblank_i;
`else
   assign w_vb_ok = 1'b1 | vblank_i;
`endif

   // Pending clear start outranks both requesters.
   assign w_arb  = (r_state == ARB) && !clear_start_i && w_vb_ok && !arst_i;
   assign w_g0   = w_arb && req0_valid_i && (!req1_valid_i || r_last1);
   assign w_g1   = w_arb && req1_valid_i && (!req0_valid_i || !r_last1);
   assign w_xfer = w_g0 || w_g1;

   assign w_px = w_g1 ? req1_x_i : req0_x_i;
   assign w_py = w_g1 ? req1_y_i : req0_y_i;
   assign w_pc = w_g1 ? req1_color_i : req0_color_i;

   assign w_inr    = (w_px <= XMAX) && (w_py <= YMAX);
   assign w_last   = (r_cx == XMAX) && (r_cy == YMAX);
   assign w_clr_st = (r_state == CLEAR);

   assign req0_ready_o = w_g0;
   assign req1_ready_o = w_g1;
   assign busy_o       = r_busy;
   assign done_o       = r_done;
   assign err_o        = r_err;
   assign we_o         = w_clr_st ? w_vb_ok : r_we;
   assign addr_x_o     = w_clr_st ? r_cx : r_x;
   assign addr_y_o     = w_clr_st ? r_cy : r_y;
   assign color_o      = w_clr_st ? r_clr : r_color;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) r_state <= ARB;
      else        r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      unique case (r_state)
         ARB:     if (clear_start_i) w_state_n = CLEAR;
         CLEAR:   if (w_vb_ok && w_last) w_state_n = ARB;
         default: w_state_n = ARB;
      endcase
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_last1 <= 1'b1;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_color <= '0;
         r_clr   <= '0;
         r_cx    <= '0;
         r_cy    <= '0;
      end else begin
         r_we   <= 1'b0;
         r_err  <= 1'b0;
         r_done <= 1'b0;
         if (r_state == ARB) begin
            if (clear_start_i) begin
               r_clr  <= clear_color_i;
               r_busy <= 1'b1;
               r_cx   <= '0;
               r_cy   <= '0;
            end else if (w_xfer) begin
               r_last1 <= w_g1;
               if (w_inr) begin
                  r_we    <= 1'b1;
                  r_x     <= w_px;
                  r_y     <= w_py;
                  r_color <= w_pc;
               end else begin
                  r_err <= 1'b1;
               end
            end
         end else if (w_vb_ok) begin
            if (w_last) begin
               // Keep the final clear pixel visible on the idle port.
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_x     <= r_cx;
               r_y     <= r_cy;
               r_color <= r_clr;
               r_cx    <= '0;
               r_cy    <= '0;
            end else if (r_cx == XMAX) begin
               r_cx <= '0;
               r_cy <= r_cy + 1'b1;
            end else begin
               r_cx <= r_cx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Directed bench for vga_fb_write_arbiter on a 4x2 frame.
module tb_vga_fb_write_arbiter;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        vb = 1'b0;
   logic        v0 = 1'b0;
   logic        v1 = 1'b0;
   logic        r0;
   logic        r1;
   logic [10:0] x0 = '0;
   logic [10:0] y0 = '0;
   logic [1:0]  c0 = '0;
   logic [10:0] x1 = '0;
   logic [10:0] y1 = '0;
   logic [1:0]  c1 = '0;
   logic        cs = 1'b0;
   logic [1:0]  cc = '0;
   logic        busy;
   logic        done;
   logic        err;
   logic        we;
   logic [10:0] ax;
   logic [10:0] ay;
   logic [1:0]  col;

   int n_chk = 0;
   int n_err = 0;

   vga_fb_write_arbiter #(
      .HD(4), .VD(2), .X_BITS(11), .Y_BITS(11), .COLOR_BITS(2)
   ) dut (
      .clk_i(clk), .arst_i(arst), .vblank_i(vb),
      .req0_valid_i(v0), .req0_ready_o(r0),
      .req0_x_i(x0), .req0_y_i(y0), .req0_color_i(c0),
      .req1_valid_i(v1), .req1_ready_o(r1),
      .req1_x_i(x1), .req1_y_i(y1), .req1_color_i(c1),
      .clear_start_i(cs), .clear_color_i(cc),
      .busy_o(busy), .done_o(done), .err_o(err),
      .we_o(we), .addr_x_o(ax), .addr_y_o(ay), .color_o(col)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input string tag, input int x, input int y,
                         input int c);
      chk({tag, ".we"}, 32'(we), 32'd1);
      chk({tag, ".x"}, 32'(ax), 32'(x));
      chk({tag, ".y"}, 32'(ay), 32'(y));
      chk({tag, ".c"}, 32'(col), 32'(c));
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, ".we"}, 32'(we), 32'd0);
      chk({tag, ".x"}, 32'(ax), 32'd0);
      chk({tag, ".y"}, 32'(ay), 32'd0);
      chk({tag, ".c"}, 32'(col), 32'd0);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".done"}, 32'(done), 32'd0);
      chk({tag, ".err"}, 32'(err), 32'd0);
      chk({tag, ".r0"}, 32'(r0), 32'd0);
      chk({tag, ".r1"}, 32'(r1), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not end");
      $fatal(1, "timeout");
   end

   initial begin
`ifdef VGA_FB_VBLANK_ONLY_EN
      vb = 1'b1;
`endif
      v0 = 1'b1;
      tick;
      tick;
      chk_rst("reset");
      v0 = 1'b0;
      arst = 1'b0;
      tick;

      // both requesters held valid: 0,1,0,1
      v0 = 1'b1; x0 = 11'd1; y0 = 11'd0; c0 = 2'd1;
      v1 = 1'b1; x1 = 11'd2; y1 = 11'd1; c1 = 2'd3;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr.r0", 32'(r0), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr.r1", 32'(r1), (i % 2 == 0) ? 32'd0 : 32'd1);
         tick;
         if (i == 3) begin
            v0 = 1'b0;
            v1 = 1'b0;
         end
         if (i % 2 == 0) chk_wr("rr.w0", 1, 0, 1);
         else            chk_wr("rr.w1", 2, 1, 3);
      end
      tick;
      chk("rr.idle_we", 32'(we), 32'd0);
      chk("rr.hold_x", 32'(ax), 32'd2);

      // single requester at the last in-range pixel
      v0 = 1'b1; x0 = 11'd3; y0 = 11'd1; c0 = 2'd2;
      #1;
      chk("single.r0", 32'(r0), 32'd1);
      chk("single.r1", 32'(r1), 32'd0);
      tick;
      v0 = 1'b0;
      chk_wr("single.w", 3, 1, 2);
      chk("single.err", 32'(err), 32'd0);
      tick;
      chk("single.idle", 32'(we), 32'd0);
      chk("single.hold_c", 32'(col), 32'd2);

      // out of range: x=1280, then x=HD, then y=VD
      v1 = 1'b1; x1 = 11'd1280; y1 = 11'd0; c1 = 2'd1;
      #1;
      chk("oor.r1", 32'(r1), 32'd1);
      tick;
      v1 = 1'b0;
      chk("oor.err", 32'(err), 32'd1);
      chk("oor.we", 32'(we), 32'd0);
      tick;
      chk("oor.err_clr", 32'(err), 32'd0);
      v0 = 1'b1; x0 = 11'd4; y0 = 11'd0;
      tick;
      v0 = 1'b0;
      chk("oor.xhd", 32'(err), 32'd1);
      v1 = 1'b1; x1 = 11'd0; y1 = 11'd2;
      tick;
      v1 = 1'b0;
      chk("oor.yvd", 32'(err), 32'd1);
      chk("oor.yvd_we", 32'(we), 32'd0);
      tick;

      // full clear, requester waiting, restart pulse ignored
      cs = 1'b1; cc = 2'd1;
      v0 = 1'b1; x0 = 11'd0; y0 = 11'd0; c0 = 2'd0;
      #1;
      chk("clr.start_r0", 32'(r0), 32'd0);
      tick;
      cs = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("clr.busy", 32'(busy), 32'd1);
         chk("clr.r0", 32'(r0), 32'd0);
         chk("clr.done", 32'(done), 32'd0);
         chk_wr("clr.px", k % 4, k / 4, 1);
         cs = (k == 3);
         cc = 2'd3;
         if (k == 7) v0 = 1'b0;
         tick;
         cs = 1'b0;
      end
      chk("clr.done_hi", 32'(done), 32'd1);
      chk("clr.busy_lo", 32'(busy), 32'd0);
      chk("clr.we_lo", 32'(we), 32'd0);
      chk("clr.hold_x", 32'(ax), 32'd3);
      chk("clr.hold_y", 32'(ay), 32'd1);
      tick;
      chk("clr.done_pulse", 32'(done), 32'd0);
      chk("clr.after_we", 32'(we), 32'd0);

      // reset after 3rd clear write, then restart
      cs = 1'b1; cc = 2'd2;
      tick;
      cs = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk_wr("abort.px", k, 0, 2);
         tick;
      end
      arst = 1'b1;
      #1;
      chk_rst("abort.rst");
      tick;
      arst = 1'b0;
      tick;
      chk("abort.no_done", 32'(done), 32'd0);
      chk("abort.we", 32'(we), 32'd0);
      cs = 1'b1; cc = 2'd3;
      tick;
      cs = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk_wr("restart.px", k % 4, k / 4, 3);
         tick;
      end
      chk("restart.done", 32'(done), 32'd1);

`ifdef VGA_FB_VBLANK_ONLY_EN
      tick;
      vb = 1'b0;
      v0 = 1'b1; x0 = 11'd2; y0 = 11'd0; c0 = 2'd1;
      #1;
      chk("vb.r0_lo", 32'(r0), 32'd0);
      tick;
      chk("vb.we_lo", 32'(we), 32'd0);
      chk("vb.r0_still", 32'(r0), 32'd0);
      vb = 1'b1;
      #1;
      chk("vb.r0_hi", 32'(r0), 32'd1);
      tick;
      v0 = 1'b0;
      chk_wr("vb.w", 2, 0, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/vga_fb_write_arbiter.md
Name: vga_fb_write_arbiter

Overview:
- Sequences all writes into the 2-bit-per-pixel video frame buffer, which has a single write port (we/addr_x/addr_y/color).
- Shares that port between two requesters (req0 = host/CPU, req1 = draw engine) using round-robin arbitration.
- Contains a built-in clear engine that sweeps the whole frame to one colour.
- Sits between the requesters and the frame buffer write port; the pixel read side is untouched.

Parameters:
- HD, 1280, horizontal display pixels
- VD, 1024, vertical display lines
- X_BITS, 11, width of x address
- Y_BITS, 11, width of y address
- COLOR_BITS, 2, pixel code width (BLACK/WHITE/BLUE/GREEN)

Ports:
- clk_i  in  1  system/pixel clock
- arst_i  in  1  asynchronous reset, active-high
- vblank_i  in  1  vertical blanking indicator from the timing generator
- req0_valid_i  in  1  requester 0 write request
- req0_ready_o  out  1  requester 0 accepted this cycle
- req0_x_i / req0_y_i / req0_color_i  in  X_BITS / Y_BITS / COLOR_BITS  requester 0 pixel
- req1_valid_i, req1_ready_o, req1_x_i, req1_y_i, req1_color_i  same widths and meanings as requester 0
- clear_start_i  in  1  one-cycle pulse: start a full-frame clear
- clear_color_i  in  COLOR_BITS  fill colour, sampled on clear_start_i
- busy_o  out  1  clear in progress
- done_o  out  1  one-cycle pulse after the last clear pixel is written
- err_o  out  1  one-cycle pulse: accepted request was out of range and dropped
- we_o  out  1  frame buffer write enable
- addr_x_o  out  X_BITS  frame buffer x address
- addr_y_o  out  Y_BITS  frame buffer y address
- color_o  out  COLOR_BITS  frame buffer write data

Behaviour:
- Reset (async, arst_i=1):
  - we_o=0, addr_x_o=0, addr_y_o=0, color_o=0.
  - busy_o=0, done_o=0, err_o=0, both ready=0.
  - FSM=ARB; round-robin pointer set so req0 wins the first tie.
- FSM states: ARB, CLEAR.
- ARB:
  - readyN_o is combinational: high only for the single granted requester with validN_i=1.
  - Only one requester valid: it is granted.
  - Both valid: the one not granted last is granted; the pointer updates only on an actual transfer.
  - Transfer = valid && ready. The next cycle drives we_o=1 with the captured x/y/colour (registered, latency 1).
  - Requester must hold valid and payload stable until ready.
- Out-of-range transfer (x>=HD or y>=VD):
  - The request is accepted (ready=1).
  - No write: we_o=0 next cycle; err_o=1 next cycle.
- clear_start_i in ARB:
  - clear_color_i latched; busy_o=1 next cycle; FSM moves to CLEAR.
  - clear_start_i has priority: no requester ready that cycle.
- CLEAR:
  - Both ready=0; one pixel written per cycle.
  - Scan order: x from 0 to HD-1 inner, y from 0 to VD-1 outer.
  - Outputs: we_o=1, addr = current counters, color_o = latched colour.
  - The cycle after the write of (HD-1,VD-1): done_o=1, busy_o=0, FSM=ARB, counters reset to 0.
  - One clear takes exactly HD*VD write cycles.
- clear_start_i while in CLEAR: ignored; it neither restarts nor extends the sweep.
- we_o is 0 on every cycle with no write.
- addr/colour outputs hold their last value when we_o=0.
- Reset mid-clear: sweep aborts immediately, all outputs return to reset values; no done_o pulse.
- Counters compare against HD-1 / VD-1 at full X_BITS/Y_BITS width; no wrap beyond the display area.

Optional Feature:
- Macro: VGA_FB_VBLANK_ONLY_EN.
- Defined:
  - Writes are issued only while vblank_i=1.
  - In ARB, both ready=0 whenever vblank_i=0.
  - In CLEAR, the sweep pauses (counters hold, we_o=0) while vblank_i=0 and resumes at the same pixel.
  - done_o semantics are unchanged.
- Not defined: vblank_i is ignored and writes proceed on any cycle.

Test Plan:
- Reset sequence, then only req0 valid with x=5, y=7, colour=2 -> req0_ready_o=1 that cycle; next cycle we_o=1, addr=(5,7), color_o=2.
- req0 and req1 both held valid for 4 cycles -> grants alternate 0,1,0,1; exactly 4 writes with matching payloads.
- req1 valid with x=1280, y=0 -> accepted; next cycle err_o=1, we_o=0.
- Use HD=4, VD=2; pulse clear_start_i with clear_color_i=1 -> busy_o=1; 8 consecutive writes in order (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(3,1), all colour 1; then done_o=1 for 1 cycle; requesters blocked throughout.
- Use HD=4, VD=2; assert arst_i after the 3rd clear write -> outputs return to reset values; no done_o; a new clear_start_i restarts the sweep at (0,0).
- With VGA_FB_VBLANK_ONLY_EN defined: req0 valid while vblank_i=0 -> ready stays 0; raise vblank_i -> transfer occurs and the write follows 1 cycle later.
